// File: rtl/branch_resolve_predict.sv
// Branch resolution and 2-bit saturating-counter BHT for the MIPS150 pipeline.
// Optional branch statistics counters enabled by defining BRANCH_STATS_EN.
module branch_resolve_predict #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned INDEX_LSB   = 2,
  parameter logic [1:0]  CTR_INIT    = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] f_pc,
  output logic             f_predict_taken,
  input  logic             x_valid,
  input  logic             x_stall,
  input  logic [WIDTH-1:0] x_pc,
  input  logic [5:0]       x_opcode,
  input  logic [4:0]       x_rt,
  input  logic [WIDTH-1:0] x_srca,
  input  logic [WIDTH-1:0] x_srcb,
  input  logic             x_predicted,
  output logic             m_valid,
  output logic             m_taken,
  output logic             m_mispredict
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] x_idx;
  logic             is_br;
  logic             cond;
  logic             a_neg;
  logic             a_zero;
  logic             upd;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_next;
  logic             unused_pc_bits;

  assign f_idx          = f_pc[INDEX_LSB +: IDX_W];
  assign x_idx          = x_pc[INDEX_LSB +: IDX_W];
  assign unused_pc_bits = ^{f_pc, x_pc};

  // Read of the registered table only: a same-cycle update is not forwarded.
  assign f_predict_taken = bht[f_idx][1];

  // Signed compares against zero reduce to sign and zero tests.
  assign a_neg  = x_srca[WIDTH-1];
  assign a_zero = (x_srca == '0);

  always_comb begin
    is_br = 1'b0;
    cond  = 1'b0;
    case (x_opcode)
      6'b000100: begin is_br = 1'b1; cond = (x_srca == x_srcb); end
      6'b000101: begin is_br = 1'b1; cond = (x_srca != x_srcb); end
      6'b000110: begin is_br = 1'b1; cond = a_neg | a_zero; end
      6'b000111: begin is_br = 1'b1; cond = ~a_neg & ~a_zero; end
      6'b000001: begin
        case (x_rt)
          5'b00000, 5'b10000: begin is_br = 1'b1; cond = a_neg; end
          5'b00001, 5'b10001: begin is_br = 1'b1; cond = ~a_neg; end
          default: begin is_br = 1'b0; cond = 1'b0; end
        endcase
      end
      default: begin is_br = 1'b0; cond = 1'b0; end
    endcase
  end

  assign upd = x_valid & is_br & ~x_stall;

  always_comb begin
    ctr_cur  = bht[x_idx];
    ctr_next = ctr_cur;
    if (cond) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bht          <= '{default: CTR_INIT};
      m_valid      <= 1'b0;
      m_taken      <= 1'b0;
      m_mispredict <= 1'b0;
    end else if (!x_stall) begin
      m_valid      <= x_valid & is_br;
      m_taken      <= cond & x_valid & is_br;
      m_mispredict <= x_valid & is_br & (cond != x_predicted);
      if (upd) bht[x_idx] <= ctr_next;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (upd) begin
      stat_branches <= stat_branches + 32'd1;
      if (cond != x_predicted) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Directed self-checking bench for branch_resolve_predict (BRANCH_STATS_EN adds stats checks).
module tb_branch_resolve_predict;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_pc;
  logic        f_predict_taken;
  logic        x_valid;
  logic        x_stall;
  logic [31:0] x_pc;
  logic [5:0]  x_opcode;
  logic [4:0]  x_rt;
  logic [31:0] x_srca;
  logic [31:0] x_srcb;
  logic        x_predicted;
  logic        m_valid;
  logic        m_taken;
  logic        m_mispredict;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_predict #(
    .WIDTH(32),
    .BHT_ENTRIES(64),
    .INDEX_LSB(2),
    .CTR_INIT(2'b01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .f_pc(f_pc),
    .f_predict_taken(f_predict_taken),
    .x_valid(x_valid),
    .x_stall(x_stall),
    .x_pc(x_pc),
    .x_opcode(x_opcode),
    .x_rt(x_rt),
    .x_srca(x_srca),
    .x_srcb(x_srcb),
    .x_predicted(x_predicted),
    .m_valid(m_valid),
    .m_taken(m_taken),
    .m_mispredict(m_mispredict)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_m(input string tag, input logic v, input logic t, input logic mp);
    chk({tag, "_valid"}, {31'd0, m_valid}, {31'd0, v});
    chk({tag, "_taken"}, {31'd0, m_taken}, {31'd0, t});
    chk({tag, "_mispred"}, {31'd0, m_mispredict}, {31'd0, mp});
  endtask

  task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
    f_pc = pc;
    #1;
    chk(tag, {31'd0, f_predict_taken}, {31'd0, exp});
  endtask

  task automatic br(input logic [5:0] op, input logic [4:0] rt, input logic [31:0] pc,
                    input logic [31:0] a, input logic [31:0] b, input logic p);
    x_valid = 1'b1; x_opcode = op; x_rt = rt; x_pc = pc;
    x_srca = a; x_srcb = b; x_predicted = p;
  endtask

  initial begin
    rst = 1'b1; f_pc = '0; x_valid = 1'b0; x_stall = 1'b0; x_pc = '0;
    x_opcode = '0; x_rt = '0; x_srca = '0; x_srcb = '0; x_predicted = 1'b0;

    // Reset and sweep every BHT entry
    tick();
    rst = 1'b0;
    chk_m("reset", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) pred_at("reset_bht", i * 4, 1'b0);

    // Taken beq, predicted not-taken; counter 01 -> 10
    br(6'b000100, 5'd0, 32'h40, 32'h1234, 32'h1234, 1'b0);
    tick();
    x_valid = 1'b0;
    chk_m("beq", 1'b1, 1'b1, 1'b1);
    pred_at("beq_bht", 32'h40, 1'b1);

    // REGIMM signed cases
    br(6'b000001, 5'b00000, 32'h04, 32'hFFFF_FFFF, 32'h0, 1'b1);
    tick();
    chk_m("bltz", 1'b1, 1'b1, 1'b0);
    br(6'b000001, 5'b10001, 32'h08, 32'h8000_0000, 32'h0, 1'b0);
    tick();
    chk_m("bgezal", 1'b1, 1'b0, 1'b0);
    br(6'b000001, 5'b00010, 32'h0C, 32'h0, 32'h0, 1'b0);
    tick();
    x_valid = 1'b0;
    chk_m("regimm_bad", 1'b0, 1'b0, 1'b0);
    pred_at("regimm_bad_bht", 32'h0C, 1'b0);
    pred_at("bltz_bht", 32'h04, 1'b1);

    // Non-branch opcode
    br(6'b100011, 5'd0, 32'h40, 32'h0, 32'h0, 1'b1);
    tick();
    x_valid = 1'b0;
    chk_m("nonbr", 1'b0, 1'b0, 1'b0);
    pred_at("nonbr_bht", 32'h40, 1'b1);

    // Saturation at PC 0x80: 01 -> 10 -> 11 -> 11 -> 11
    for (int i = 0; i < 4; i++) begin
      br(6'b000111, 5'd0, 32'h80, 32'd5, 32'h0, 1'b1);
      tick();
      chk_m("bgtz_t", 1'b1, 1'b1, 1'b0);
    end
    br(6'b000111, 5'd0, 32'h80, 32'd0, 32'h0, 1'b1);
    tick();
    x_valid = 1'b0;
    chk_m("bgtz_nt", 1'b1, 1'b0, 1'b1);
    pred_at("sat_11_to_10", 32'h80, 1'b1);
    br(6'b000111, 5'd0, 32'h80, 32'd0, 32'h0, 1'b1);
    tick();
    x_valid = 1'b0;
    pred_at("sat_to_01", 32'h80, 1'b0);
    for (int i = 0; i < 2; i++) begin
      br(6'b000111, 5'd0, 32'h80, 32'hFFFF_FFF0, 32'h0, 1'b0);
      tick();
    end
    x_valid = 1'b0;
    chk_m("bgtz_neg", 1'b1, 1'b0, 1'b0);
    // One taken from 00 gives 01 (still not-taken); an unsaturated counter would differ
    br(6'b000111, 5'd0, 32'h80, 32'd1, 32'h0, 1'b0);
    tick();
    x_valid = 1'b0;
    chk_m("bgtz_t2", 1'b1, 1'b1, 1'b1);
    pred_at("sat_floor", 32'h80, 1'b0);

    // Stall: m_* hold (1,1,1), counter at idx 5 stays 01
    x_stall = 1'b1;
    br(6'b000101, 5'd0, 32'h14, 32'd1, 32'd2, 1'b1);
    tick();
    tick();
    chk_m("stall", 1'b1, 1'b1, 1'b1);
    pred_at("stall_bht", 32'h14, 1'b0);
    x_stall = 1'b0;
    x_valid = 1'b0;
    tick();
    chk_m("unstall_idle", 1'b0, 1'b0, 1'b0);

    // Collision: update idx 5 while fetch reads idx 5
    f_pc = 32'h14;
    br(6'b000101, 5'd0, 32'h14, 32'd1, 32'd2, 1'b0);
    #1;
    chk("collide_old", {31'd0, f_predict_taken}, 32'd0);
    tick();
    x_valid = 1'b0;
    chk("collide_new", {31'd0, f_predict_taken}, 32'd1);
    pred_at("alias_idx5", 32'h114, 1'b1);

    // Reset together with a valid branch
    br(6'b000100, 5'd0, 32'h40, 32'd7, 32'd7, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    x_valid = 1'b0;
    chk_m("rst_br", 1'b0, 1'b0, 1'b0);
    pred_at("rst_bht40", 32'h40, 1'b0);
    pred_at("rst_bht14", 32'h14, 1'b0);

`ifdef BRANCH_STATS_EN
    chk("stat_rst_br", stat_branches, 32'd0);
    chk("stat_rst_mp", stat_mispredicts, 32'd0);
    // 10 taken beqs, the first 3 predicted not-taken; a stalled one and a non-branch do not count
    for (int i = 0; i < 10; i++) begin
      br(6'b000100, 5'd0, 32'h20, 32'd3, 32'd3, (i >= 3));
      tick();
      if (i == 5) begin
        x_stall = 1'b1;
        tick();
        x_stall = 1'b0;
        br(6'b001000, 5'd0, 32'h20, 32'd3, 32'd3, 1'b0);
        tick();
      end
    end
    x_valid = 1'b0;
    tick();
    chk("stat_branches", stat_branches, 32'd10);
    chk("stat_mispredicts", stat_mispredicts, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_predict.md
Name: branch_resolve_predict

Overview:
- Next-generation branch unit for the MIPS150 pipeline.
- Resolves conditional branches in execute and registers the outcome into the memory stage.
- Holds a parametrised branch history table (BHT) of 2-bit saturating counters. Fetch reads the BHT for a taken/not-taken prediction; execute writes it with resolved outcomes.
- Flags mispredictions so the control unit can flush.

Parameters:
- WIDTH, 32, datapath width of PC and operands
- BHT_ENTRIES, 64, number of counters; power of two, minimum 2
- INDEX_LSB, 2, lowest PC bit used for the BHT index (word-aligned PCs)
- CTR_INIT, 2'b01, counter value loaded on reset (weakly not-taken)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- f_pc  input  WIDTH  fetch-stage PC
- f_predict_taken  output  1  prediction for f_pc
- x_valid  input  1  execute-stage instruction valid
- x_stall  input  1  execute/memory stage hold
- x_pc  input  WIDTH  PC of execute-stage instruction
- x_opcode  input  6  instruction opcode
- x_rt  input  5  rt field (REGIMM selector)
- x_srca  input  WIDTH  rs operand, forwarded
- x_srcb  input  WIDTH  rt operand, forwarded
- x_predicted  input  1  prediction carried down the pipe with the instruction
- m_valid  output  1  registered: a branch was resolved
- m_taken  output  1  registered resolved direction
- m_mispredict  output  1  registered: resolved direction differs from x_predicted

Behaviour:
- The design has one clock. Reset is synchronous and active-high; clk and rst are sampled on the rising edge.
- Index: idx = pc[INDEX_LSB + log2(BHT_ENTRIES) - 1 : INDEX_LSB]. The same function is used for f_pc and x_pc.
- f_predict_taken = bht[idx(f_pc)][1]. It is a combinational read of the registered table, with zero latency.
- Branch decode (is_br), with comparisons signed over WIDTH bits:
  - 000100 beq: A==B
  - 000101 bne: A!=B
  - 000110 blez: A<=0
  - 000111 bgtz: A>0
  - 000001 with rt in {00000, 10000}: bltz/bltzal, A<0
  - 000001 with rt in {00001, 10001}: bgez/bgezal, A>=0
  - Any other opcode/rt: is_br=0.
- Resolution latency is 1 cycle. On an edge with x_stall=0:
  - m_valid <= x_valid & is_br
  - m_taken <= cond & x_valid & is_br
  - m_mispredict <= x_valid & is_br & (cond != x_predicted)
- When x_stall=1: m_* outputs hold their values and the BHT is not written.
- BHT update happens on the same edge as resolution, only when x_stall=0, x_valid=1 and is_br=1.
  - Taken: counter +1, saturating at 2'b11.
  - Not taken: counter -1, saturating at 2'b00.
- Read/write collision (idx(f_pc)==idx(x_pc) while an update occurs): f_predict_taken shows the pre-update value. The new value is visible from the next cycle. There is no write-through.
- Aliasing: different PCs with the same index share a counter. This is intended; there are no tags.
- Reset: m_valid, m_taken and m_mispredict go to 0, and every counter goes to CTR_INIT.
  - rst has priority over x_stall and over any update.
  - A branch resolving in the same cycle as rst is discarded.
- A non-branch with x_valid=1 and x_stall=0 produces m_valid=0, m_taken=0, m_mispredict=0, and the BHT is unchanged.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, the block adds two outputs, stat_branches (32 bits) and stat_mispredicts (32 bits).
  - Both reset to 0.
  - stat_branches increments on each edge where a BHT update occurs.
  - stat_mispredicts increments on each such edge where cond != x_predicted.
  - Both wrap from 32'hFFFFFFFF to 0.
- When undefined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then read BHT state: assert rst for 1 cycle, then sweep f_pc across all indices -> f_predict_taken=0 for every entry, and m_valid=0, m_taken=0, m_mispredict=0.
- Taken beq with wrong prediction: beq (000100) at x_pc=0x40, A=B=0x1234, x_predicted=0 -> next cycle m_valid=1, m_taken=1, m_mispredict=1. Afterwards, f_pc=0x40 gives f_predict_taken=1, since the counter went 01 to 10.
- Signed REGIMM cases:
  - bltz (rt=00000), A=0xFFFFFFFF -> m_taken=1.
  - bgezal (rt=10001), A=0x80000000 -> m_taken=0.
  - rt=00010 -> m_valid=0 and the BHT is unchanged.
- Counter saturation: 4 taken bgtz at PC 0x80 with A=5, then 1 not-taken -> counter goes 11 to 10, prediction stays 1. Then 3 more not-taken -> counter reaches 00 and stays there.
- Stall and collision:
  - x_stall=1 with a valid bne -> m_* outputs hold and the counter is unchanged.
  - An update at idx X with f_pc also at idx X -> the old prediction is shown that cycle and the new one the next cycle.
  - rst asserted together with a valid branch -> outputs are 0 and the counter is back at CTR_INIT.
- Statistics (BRANCH_STATS_EN builds only): 10 branches with 3 mispredicted -> stat_branches=10, stat_mispredicts=3.
